mix_engine: RTL and testbench

MIX_ENGINE -- requirements
Module: mix_engine

---
 rtl/mix_pkg.sv | 13 +
 rtl/mix_if.sv | 16 +
 rtl/mix_sat_scale.sv | 24 ++
 rtl/mix_engine.sv | 149 ++++++++++++++
 tb/tb_mix_engine.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mix_pkg.sv
// mix_pkg: shared state encoding, sample-half width and saturation limits for the mixer
package mix_pkg;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_HDR   = 3'd1;
    localparam state_t S_FETCH = 3'd2;
    localparam state_t S_SCALE = 3'd3;
    localparam state_t S_SUM   = 3'd4;
    localparam state_t S_OUT   = 3'd5;
    localparam int HALF_W  = 16;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;
endpackage

// File: rtl/mix_if.sv
// mix_if: SDRAM read port and stereo output stream of the mixer
interface mix_if
    import mix_pkg::*;
#(
    parameter int ADDR_W = 23
) ();
    logic                o_rd;
    logic [ADDR_W-1:0]   o_addr;
    logic [2*HALF_W-1:0] i_rdata;
    logic                i_rd_done;
    logic                o_valid;
    logic [2*HALF_W-1:0] o_data;
    logic                i_ready;
    modport master (output o_rd, o_addr, o_valid, o_data, input i_rdata, i_rd_done, i_ready);
    modport slave  (input o_rd, o_addr, o_valid, o_data, output i_rdata, i_rd_done, i_ready);
endinterface

// File: rtl/mix_sat_scale.sv
// mix_sat_scale: gain-scales one 16-bit half into a running sum and saturates the sum back to 16 bits
module mix_sat_scale
    import mix_pkg::*;
#(
    parameter int GAIN_W = 8,
    parameter int SUM_W  = 26
) (
    input  logic signed [HALF_W-1:0] sample,
    input  logic        [GAIN_W-1:0] gain,
    input  logic signed [SUM_W-1:0]  acc,
    output logic signed [SUM_W-1:0]  acc_next,
    output logic signed [HALF_W-1:0] sat,
    output logic                     clip
);
    localparam int PW = HALF_W + GAIN_W + 1;
    logic signed [PW-1:0] prod;
    logic hi, lo;
    assign prod     = PW'(sample) * PW'($signed({1'b0, gain}));
    assign acc_next = acc + SUM_W'(prod >>> (GAIN_W - 1));
    assign hi       = acc > SUM_W'(SAT_MAX);
    assign lo       = acc < SUM_W'(SAT_MIN);
    assign clip     = hi | lo;
    assign sat      = hi ? HALF_W'(SAT_MAX) : lo ? HALF_W'(SAT_MIN) : acc[HALF_W-1:0];
endmodule

// File: rtl/mix_engine.sv
// mix_engine: multi-channel SDRAM sample mixer with per-channel gain and zero-order-hold output
module mix_engine
    import mix_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 23,
    parameter int GAIN_W = 8,
    parameter int REPEAT = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_CH-1:0]        i_start,
    input  logic [N_CH*ADDR_W-1:0] i_base,
    input  logic [N_CH*GAIN_W-1:0] i_gain,
    input  logic [N_CH-1:0]        i_loop,
    input  logic                   i_stop,
    output logic [N_CH-1:0]        o_active,
    output logic                   o_done,
    output logic                   o_clip,
    mix_if.master                  bus
);
    localparam int IW    = $clog2(N_CH);
    localparam int SUM_W = HALF_W + GAIN_W + $clog2(N_CH);
    localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

    logic [N_CH-1:0][ADDR_W-1:0]   base_a, ptr, lim;
    logic [N_CH-1:0][GAIN_W-1:0]   gain_a;
    logic [N_CH-1:0][2*HALF_W-1:0] samp;
    logic [N_CH-1:0] pend, pend_n, active, act_hdr, fin, clr;
    state_t state;
    logic [IW-1:0] idx, low;
    logic rd, valid, hdr_take, fetch_adv, clip_l, clip_r;
    logic [ADDR_W-1:0] addr, nxt, len;
    logic [2*HALF_W-1:0] data;
    logic [2:0] beats;
    logic signed [SUM_W-1:0] acc_l, acc_r, acc_l_n, acc_r_n;
    logic signed [HALF_W-1:0] sat_l, sat_r;

    assign base_a        = i_base;
    assign gain_a        = i_gain;
    assign len           = bus.i_rdata[ADDR_W-1:0];
    assign nxt           = addr + ADDR_W'(1);
    assign hdr_take      = state == S_HDR && rd && bus.i_rd_done;
    assign fetch_adv     = state == S_FETCH && (rd ? bus.i_rd_done : !(active[idx] && ptr[idx] != lim[idx]));
    assign o_active      = active;
    assign bus.o_rd      = rd;
    assign bus.o_addr    = addr;
    assign bus.o_valid   = valid;
    assign bus.o_data    = data;

    mix_sat_scale #(.GAIN_W(GAIN_W), .SUM_W(SUM_W)) u_left (
        .sample(samp[idx][2*HALF_W-1:HALF_W]), .gain(gain_a[idx]), .acc(acc_l),
        .acc_next(acc_l_n), .sat(sat_l), .clip(clip_l)
    );
    mix_sat_scale #(.GAIN_W(GAIN_W), .SUM_W(SUM_W)) u_right (
        .sample(samp[idx][HALF_W-1:0]), .gain(gain_a[idx]), .acc(acc_r),
        .acc_next(acc_r_n), .sat(sat_r), .clip(clip_r)
    );

    // Pending mask with the landing header retired, its lowest set channel, and the active mask after that header
    always_comb begin
        clr = '0;
        clr[idx] = hdr_take;
        pend_n = (pend & ~clr) | i_start;
        act_hdr = active;
        act_hdr[idx] = |len;
        low = '0;
        for (int i = N_CH - 1; i >= 0; i--) low = pend_n[i] ? IW'(i) : low;
    end

    // Channel bookkeeping, SDRAM read sequencing, accumulation and output framing; stop overrides everything
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE; pend <= '0; active <= '0; fin <= '0; ptr <= '0; lim <= '0; samp <= '0;
            idx <= '0; rd <= 1'b0; addr <= '0; valid <= 1'b0; data <= '0; beats <= '0;
            acc_l <= '0; acc_r <= '0; o_done <= 1'b0; o_clip <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_clip <= 1'b0;
            pend <= pend_n;
            if (i_stop) begin
                state <= S_IDLE; pend <= '0; active <= '0; fin <= '0;
                rd <= 1'b0; valid <= 1'b0; o_done <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (|pend_n) begin
                        state <= S_HDR;
                        idx <= low;
                    end
                    S_HDR: if (!rd) begin
                        rd <= 1'b1;
                        addr <= base_a[idx];
                    end else if (bus.i_rd_done) begin
                        rd <= 1'b0;
                        ptr[idx] <= nxt;
                        lim[idx] <= nxt + len;
                        active[idx] <= |len;
                        fin[idx] <= 1'b0;
                        idx <= |pend_n ? low : '0;
                        state <= |pend_n ? S_HDR : |act_hdr ? S_FETCH : S_IDLE;
                    end
                    S_FETCH: begin
                        if (!rd && active[idx] && ptr[idx] != lim[idx]) begin
                            rd <= 1'b1;
                            addr <= ptr[idx];
                        end
                        if (fetch_adv) begin
                            rd <= 1'b0;
                            samp[idx] <= rd ? bus.i_rdata : '0;
                            if (rd) ptr[idx] <= (nxt == lim[idx] && i_loop[idx]) ? base_a[idx] + ADDR_W'(1) : nxt;
                            if (rd && nxt == lim[idx] && !i_loop[idx]) fin[idx] <= 1'b1;
                            idx <= idx == LAST ? '0 : idx + IW'(1);
                            if (idx == LAST) begin
                                state <= S_SCALE;
                                acc_l <= '0;
                                acc_r <= '0;
                            end
                        end
                    end
                    S_SCALE: begin
                        acc_l <= acc_l_n;
                        acc_r <= acc_r_n;
                        idx <= idx == LAST ? '0 : idx + IW'(1);
                        if (idx == LAST) state <= S_SUM;
                    end
                    S_SUM: begin
                        data <= {sat_l, sat_r};
                        o_clip <= clip_l | clip_r;
                        valid <= 1'b1;
                        beats <= '0;
                        state <= S_OUT;
                    end
                    S_OUT: if (bus.i_ready) begin
                        beats <= beats + 3'd1;
                        if (beats == 3'(REPEAT - 1)) begin
                            valid <= 1'b0;
                            active <= active & ~fin;
                            fin <= '0;
                            idx <= |pend_n ? low : '0;
                            state <= |pend_n ? S_HDR : |(active & ~fin) ? S_FETCH : S_IDLE;
                            o_done <= !(|pend_n) && !(|(active & ~fin));
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mix_engine.sv
// tb_mix_engine: directed scoreboard bench for mix_engine with a simple SDRAM responder
module tb_mix_engine;
    import mix_pkg::*;
    localparam int N_CH = 4, ADDR_W = 23, GAIN_W = 8, REPEAT = 2;

    logic clk = 1'b0, rst = 1'b1, stop = 1'b0, done, clip;
    logic [N_CH-1:0] start = '0, loop = '0, active;
    logic [N_CH*ADDR_W-1:0] base = '0;
    logic [N_CH*GAIN_W-1:0] gain = '0;
    logic [31:0] mem [256];
    logic [32:0] q [$];
    logic [32:0] exp_beat;
    logic [ADDR_W-1:0] a0 = '0;
    int tests = 0, fails = 0, lat = 1, wcnt = 0;
    bit mem_en = 1'b1, late = 1'b0;

    mix_if #(.ADDR_W(ADDR_W)) bus ();

    mix_engine #(.N_CH(N_CH), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W), .REPEAT(REPEAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base), .i_gain(gain), .i_loop(loop),
        .i_stop(stop), .o_active(active), .o_done(done), .o_clip(clip), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input int ga, input logic [31:0] b, input int gb);
        int l, r;
        logic c;
        l = ((int'($signed(a[31:16])) * ga) >>> 7) + ((int'($signed(b[31:16])) * gb) >>> 7);
        r = ((int'($signed(a[15:0])) * ga) >>> 7) + ((int'($signed(b[15:0])) * gb) >>> 7);
        c = l > 32767 || l < -32768 || r > 32767 || r < -32768;
        l = l > 32767 ? 32767 : l < -32768 ? -32768 : l;
        r = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
        return {c, l[15:0], r[15:0]};
    endfunction

    task automatic push(input logic [32:0] e);
        q.push_back(e);
        for (int k = 1; k < REPEAT; k++) q.push_back({1'b0, e[31:0]});
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 400 && !done; k++) tick();
        chk(tag, done, 1);
    endtask

    // Output beats are compared in order against the expected-beat queue
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (q.size() == 0) chk("unexpected_beat", bus.o_valid, 0);
            else begin
                exp_beat = q.pop_front();
                chk("beat", {clip, bus.o_data}, exp_beat);
            end
        end
    end

    // SDRAM model: completes a read after lat cycles and checks the address holds while waiting
    initial begin
        bus.i_rd_done = 1'b0;
        bus.i_rdata = '0;
        forever begin
            tick();
            if (bus.i_rd_done || !bus.o_rd || !mem_en) begin
                bus.i_rd_done = late;
                wcnt = 0;
            end else begin
                if (wcnt == 0) a0 = bus.o_addr;
                else chk("addr_stable", bus.o_addr, a0);
                wcnt++;
                if (wcnt >= lat) begin
                    bus.i_rd_done = 1'b1;
                    bus.i_rdata = mem[bus.o_addr[7:0]];
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'd3; mem[8'h11] = 32'h00100020; mem[8'h12] = 32'h7FFF8000; mem[8'h13] = 32'h0;
        mem[8'h30] = 32'd2; mem[8'h31] = 32'h7FFF7FFF; mem[8'h32] = 32'h80007FFF;
        mem[8'h40] = 32'd2; mem[8'h41] = 32'h11112222; mem[8'h42] = 32'hC000F000;
        mem[8'h50] = 32'd0;
        mem[8'h60] = 32'd1; mem[8'h61] = 32'h12345678;
        bus.i_ready = 1'b1;
        repeat (3) tick();
        chk("rst_rd", bus.o_rd, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_addr", bus.o_addr, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        chk("rst_clip", clip, 0);
        rst = 1'b0;
        tick();

        gain = {4{8'd128}};
        base[0 +: ADDR_W] = 23'h10;
        push(model(32'h00100020, 128, 0, 0));
        push(model(32'h7FFF8000, 128, 0, 0));
        push(model(32'h0, 128, 0, 0));
        start = 4'b0001; tick(); start = '0;
        for (int k = 0; k < 100 && !bus.o_valid; k++) tick();
        chk("t1_active_playing", active, 4'b0001);
        wait_done("t1_done");
        chk("t1_active_off", active, 0);
        chk("t1_drained", q.size(), 0);

        gain = {8'd128, 8'd128, 8'd255, 8'd255};
        base[0 +: ADDR_W] = 23'h30;
        base[ADDR_W +: ADDR_W] = 23'h30;
        push(model(32'h7FFF7FFF, 255, 32'h7FFF7FFF, 255));
        push(model(32'h80007FFF, 255, 32'h80007FFF, 255));
        start = 4'b0011; tick(); start = '0;
        wait_done("t2_done");
        chk("t2_active_off", active, 0);
        chk("t2_drained", q.size(), 0);

        gain = {8'd128, 8'd128, 8'd64, 8'd128};
        base[ADDR_W +: ADDR_W] = 23'h40;
        loop = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            push(model(32'h0, 128, 32'h11112222, 64));
            push(model(32'h0, 128, 32'hC000F000, 64));
        end
        start = 4'b0010; tick(); start = '0;
        for (int k = 0; k < 600 && q.size() != 0; k++) tick();
        chk("t3_frames", q.size(), 0);
        chk("t3_still_active", active, 4'b0010);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t3_stop_done", done, 1);
        chk("t3_stop_active", active, 0);
        chk("t3_stop_valid", bus.o_valid, 0);
        chk("t3_stop_rd", bus.o_rd, 0);
        tick();
        chk("t3_done_one_cycle", done, 0);
        loop = '0;
        repeat (5) tick();

        gain = {4{8'd128}};
        base[2*ADDR_W +: ADDR_W] = 23'h50;
        start = 4'b0100; tick(); start = '0;
        repeat (4) tick();
        chk("t4_active_mid", active, 0);
        repeat (20) tick();
        chk("t4_active", active, 0);
        chk("t4_rd_idle", bus.o_rd, 0);
        chk("t4_valid", bus.o_valid, 0);

        lat = 5;
        bus.i_ready = 1'b0;
        base[0 +: ADDR_W] = 23'h60;
        push(model(32'h12345678, 128, 0, 0));
        start = 4'b0001; tick(); start = '0;
        for (int k = 0; k < 300 && !bus.o_valid; k++) tick();
        chk("t5_valid_seen", bus.o_valid, 1);
        repeat (10) begin
            tick();
            chk("t5_hold_valid", bus.o_valid, 1);
            chk("t5_hold_data", bus.o_data, 32'h12345678);
        end
        bus.i_ready = 1'b1;
        wait_done("t5_done");
        chk("t5_drained", q.size(), 0);

        base[0 +: ADDR_W] = 23'h10;
        start = 4'b0001; tick(); start = '0;
        for (int k = 0; k < 300 && !(bus.o_rd && bus.o_addr == 23'h11); k++) tick();
        chk("t6_fetch_addr", bus.o_addr, 23'h11);
        mem_en = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_rd", bus.o_rd, 0);
        chk("t6_rst_valid", bus.o_valid, 0);
        chk("t6_rst_addr", bus.o_addr, 0);
        chk("t6_rst_data", bus.o_data, 0);
        chk("t6_rst_active", active, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_clip", clip, 0);
        tick();
        rst = 1'b0;
        late = 1'b1;
        tick();
        late = 1'b0;
        repeat (3) tick();
        chk("t6_late_rd", bus.o_rd, 0);
        chk("t6_late_active", active, 0);
        chk("t6_late_valid", bus.o_valid, 0);
        chk("t6_late_addr", bus.o_addr, 0);
        chk("final_queue", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
